cell_read_scheduler: RTL and testbench

- Consumer end of the pointer-memory read interface: picks an egress port, pops cell pointers from that port's linked list via ptr_rdy/ptr_ack/ptr_dout, and streams the cell words out of cell data memory onto one egress bus.
- After a cell's last word is read, returns the pointer to the free queue via FQ_wr/FQ_din.
- Sits between the cell pointer memory controller and the egress MAC mux.

---
 rtl/cell_read_scheduler_pkg.sv | 39 +++
 rtl/cell_read_scheduler_fifo.sv | 40 ++++
 rtl/cell_read_scheduler.sv | 144 ++++++++++++++
 tb/tb_cell_read_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_read_scheduler_pkg.sv
// Shared definitions for the cell read scheduler: port count, pointer layout,
// FSM encoding and the round-robin pick helper.
package cell_read_scheduler_pkg;

  localparam int NUM_PORTS    = 4;
  localparam int PORT_W       = 2;
  localparam int PTR_W        = 16;
  localparam int PTR_LAST_BIT = 15;
  localparam int PTR_ADDR_MSB = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_CAPTURE,
    S_READ,
    S_WAIT_NEXT
  } state_e;

  // Cell pointer as delivered by the pointer memory controller.
  typedef struct packed {
    logic                  last;   // last cell of the frame
    logic                  rsvd;   // multicast marker upstream; carried, not interpreted
    logic [4:0]            unused;
    logic [PTR_ADDR_MSB:0] addr;   // cell address in data memory
  } ptr_t;

  // First requesting port after 'last', wrapping mod NUM_PORTS.
  function automatic logic [PORT_W-1:0] rr_pick(input logic [PORT_W-1:0] last,
                                                input logic [NUM_PORTS-1:0] req);
    logic [PORT_W-1:0] idx;
    rr_pick = last;
    // Walk farthest-first so the nearest requester is the one left standing.
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = last + PORT_W'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/cell_read_scheduler_fifo.sv
// Four-entry synchronous FIFO holding tagged egress words {port, sop, eop, data}.
module cell_out_fifo #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [2:0]   count
);

  logic [W-1:0] mem [4];
  logic [1:0]   wp, rp;
  logic         do_push, do_pop;

  assign do_pop  = pop && (count != 3'd0);
  assign do_push = push && ((count != 3'd4) || do_pop);
  assign dout    = mem[rp];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wp] <= din;
  end

  // Pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 2'd1;
      if (do_pop)  rp <= rp + 2'd1;
      count <= count + 3'(do_push) - 3'(do_pop);
    end
  end

endmodule

// File: rtl/cell_read_scheduler.sv
// Egress cell read scheduler: arbitrates ports, pops cell pointers, streams
// cell words out of data memory and returns each pointer to the free queue.
module cell_read_scheduler
  import cell_read_scheduler_pkg::*;
#(
  parameter int CELL_WORDS = 4,
  parameter int DATA_W     = 32,
  parameter int ACK_GAP    = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [3:0]                          ptr_rdy,
  output logic [3:0]                          ptr_ack,
  input  logic [63:0]                         ptr_dout,
  output logic                                cell_rd_en,
  output logic [8+$clog2(CELL_WORDS):0]       cell_rd_addr,
  input  logic [DATA_W-1:0]                   cell_rd_data,
  output logic                                FQ_wr,
  output logic [15:0]                         FQ_din,
  output logic                                out_valid,
  output logic [1:0]                          out_port,
  output logic [DATA_W-1:0]                   out_data,
  output logic                                out_sop,
  output logic                                out_eop,
  input  logic                                out_ready
);

  localparam int WIDX_W = $clog2(CELL_WORDS);
  localparam int HO_W   = $clog2(ACK_GAP) + 1;
  localparam int TAG_W  = PORT_W + 2;

  state_e                              state, state_nxt;
  logic [PORT_W-1:0]                   cur_port, rr, grant;
  logic [HO_W-1:0]                     holdoff;
  ptr_t                                cur_ptr;
  logic [WIDX_W-1:0]                   word_idx;
  logic                                first_cell;
  logic                                rd_en, fq_wr, room, last_word;
  logic                                cur_sop, cur_eop;
  logic                                rd_vld_q;
  logic [TAG_W-1:0]                    rd_tag_q;
  logic [2:0]                          fifo_count;
  logic [TAG_W+DATA_W-1:0]             fifo_dout;
  logic [NUM_PORTS-1:0][PTR_W-1:0]     lanes;

  assign lanes     = ptr_dout;
  assign grant     = rr_pick(rr, ptr_rdy);
  // Counting the in-flight read keeps the FIFO from ever overflowing.
  assign room      = (4'(fifo_count) + 4'(rd_vld_q)) < 4'd4;
  assign last_word = (word_idx == WIDX_W'(CELL_WORDS - 1));
  assign cur_sop   = first_cell && (word_idx == '0);
  assign cur_eop   = cur_ptr.last && last_word;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the ack, read and free-queue strobes.
  always_comb begin
    state_nxt = state;
    ptr_ack   = '0;
    rd_en     = 1'b0;
    fq_wr     = 1'b0;
    case (state)
      S_IDLE:      if (holdoff == '0 && |ptr_rdy) state_nxt = S_ACK;
      S_ACK: begin
        ptr_ack[cur_port] = 1'b1;
        state_nxt         = S_CAPTURE;
      end
      S_CAPTURE:   state_nxt = S_READ;
      S_READ: begin
        if (room) begin
          rd_en = 1'b1;
          // The cell is fully fetched once its last word is issued.
          if (last_word) begin
            fq_wr     = 1'b1;
            state_nxt = cur_ptr.last ? S_IDLE : S_WAIT_NEXT;
          end
        end
      end
      S_WAIT_NEXT: if (ptr_rdy[cur_port] && holdoff == '0) state_nxt = S_ACK;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Arbitration, ack holdoff, pointer capture and word sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr         <= 2'd3;
      cur_port   <= '0;
      holdoff    <= '0;
      cur_ptr    <= '0;
      word_idx   <= '0;
      first_cell <= 1'b0;
    end else begin
      if (state == S_IDLE && state_nxt == S_ACK) begin
        cur_port   <= grant;
        rr         <= grant;
        first_cell <= 1'b1;
      end
      if (state == S_ACK)         holdoff <= HO_W'(ACK_GAP - 1);
      else if (holdoff != '0)     holdoff <= holdoff - 1'b1;
      if (state == S_CAPTURE) begin
        cur_ptr  <= lanes[cur_port];
        word_idx <= '0;
      end
      if (rd_en) begin
        word_idx <= word_idx + 1'b1;
        if (last_word) first_cell <= 1'b0;
      end
    end
  end

  // Read-return tracking: tag travels alongside the one-cycle memory latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
      rd_tag_q <= '0;
    end else begin
      rd_vld_q <= rd_en;
      rd_tag_q <= {cur_port, cur_sop, cur_eop};
    end
  end

  cell_out_fifo #(.W(TAG_W + DATA_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_vld_q),
    .din   ({rd_tag_q, cell_rd_data}),
    .pop   (out_valid && out_ready),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  assign cell_rd_en   = rd_en;
  assign cell_rd_addr = rd_en ? {cur_ptr.addr, word_idx} : '0;
  assign FQ_wr        = fq_wr;
  assign FQ_din       = fq_wr ? cur_ptr : '0;
  assign out_valid    = (fifo_count != 3'd0);
  assign {out_port, out_sop, out_eop, out_data} = out_valid ? fifo_dout : '0;

endmodule

// File: tb/tb_cell_read_scheduler.sv
// Directed bench for cell_read_scheduler with a pointer-list responder,
// a one-cycle-latency cell memory model and an event log.
module tb_cell_read_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ptr_rdy = '0;
  logic [3:0]  ptr_ack;
  logic [63:0] ptr_dout = '0;
  logic        cell_rd_en;
  logic [10:0] cell_rd_addr;
  logic [31:0] cell_rd_data = '0;
  logic        FQ_wr;
  logic [15:0] FQ_din;
  logic        out_valid;
  logic [1:0]  out_port;
  logic [31:0] out_data;
  logic        out_sop, out_eop;
  logic        out_ready = 1'b0;

  cell_read_scheduler dut (
    .clk(clk), .rst(rst), .ptr_rdy(ptr_rdy), .ptr_ack(ptr_ack), .ptr_dout(ptr_dout),
    .cell_rd_en(cell_rd_en), .cell_rd_addr(cell_rd_addr), .cell_rd_data(cell_rd_data),
    .FQ_wr(FQ_wr), .FQ_din(FQ_din), .out_valid(out_valid), .out_port(out_port),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [15:0] pmem [4][16];
  int          phead [4] = '{default: 0};
  int          ptail [4] = '{default: 0};

  int          ack_cyc[$], ack_port[$], rd_addr[$], rd_cyc[$], fq_cyc[$];
  logic [15:0] fq_val[$];
  int          o_port[$], o_sop[$], o_eop[$], o_cyc[$];
  logic [31:0] o_data[$];
  int          rd_tot = 0, out_tot = 0, max_occ = 0;
  logic        rd_pend = 1'b0;
  logic [10:0] rd_pend_addr = '0;

  function automatic logic [31:0] mem_word(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  // Sample DUT at negedge; then model memory and pointer-list responder.
  always @(negedge clk) begin
    cyc++;
    for (int p = 0; p < 4; p++)
      if (ptr_ack[p] === 1'b1) begin ack_cyc.push_back(cyc); ack_port.push_back(p); end
    if (cell_rd_en === 1'b1) begin
      rd_addr.push_back(int'(cell_rd_addr)); rd_cyc.push_back(cyc); rd_tot++;
    end
    if (rd_tot - out_tot > max_occ) max_occ = rd_tot - out_tot;
    if (FQ_wr === 1'b1) begin fq_val.push_back(FQ_din); fq_cyc.push_back(cyc); end
    if (out_valid === 1'b1 && out_ready) begin
      o_port.push_back(int'(out_port)); o_sop.push_back(int'(out_sop));
      o_eop.push_back(int'(out_eop)); o_data.push_back(out_data); o_cyc.push_back(cyc);
      out_tot++;
    end
    if (rd_pend) cell_rd_data = mem_word(int'(rd_pend_addr));
    rd_pend      = (cell_rd_en === 1'b1);
    rd_pend_addr = cell_rd_addr;
    for (int p = 0; p < 4; p++) begin
      if (ptr_ack[p] === 1'b1 && phead[p] != ptail[p]) begin
        ptr_dout[16*p +: 16] = pmem[p][phead[p]];
        phead[p]++;
      end
      ptr_rdy[p] = (phead[p] != ptail[p]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want summary");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ptr(input int p, input logic [15:0] v);
    pmem[p][ptail[p]] = v;
    ptail[p]++;
    ptr_rdy[p] = 1'b1;
  endtask

  task automatic clear_logs;
    ack_cyc.delete(); ack_port.delete(); rd_addr.delete(); rd_cyc.delete();
    fq_val.delete(); fq_cyc.delete(); o_port.delete(); o_sop.delete();
    o_eop.delete(); o_data.delete(); o_cyc.delete();
    rd_tot = 0; out_tot = 0; max_occ = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if ({ptr_ack, cell_rd_en, cell_rd_addr, FQ_wr, FQ_din} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got ack=%h rd=%b addr=%h fq=%b din=%h want all 0",
               ptr_ack, cell_rd_en, cell_rd_addr, FQ_wr, FQ_din);
    end
    n_cmp++;
    if ({out_valid, out_port, out_data, out_sop, out_eop} !== '0) begin
      n_bad++;
      $display("FAIL reset_out: got v=%b port=%0d data=%h sop=%b eop=%b want all 0",
               out_valid, out_port, out_data, out_sop, out_eop);
    end
    tick(1);
    clear_logs();
  endtask

  task automatic test_single_cell;
    clear_logs();
    out_ready = 1'b1;
    push_ptr(1, 16'h8005);
    tick(20);
    n_cmp++;
    if (ack_port.size() != 1 || ack_port[0] != 1) begin
      n_bad++; $display("FAIL single_ack: got n=%0d port=%0d want n=1 port=1", ack_port.size(), ack_port[0]);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rd_addr.size() != 4 || rd_addr[i] != 20 + i || rd_cyc[i] != rd_cyc[0] + i) begin
        n_bad++; $display("FAIL single_rd%0d: got addr=%0d cyc=%0d want addr=%0d cyc=%0d",
                          i, rd_addr[i], rd_cyc[i], 20 + i, rd_cyc[0] + i);
      end
    end
    n_cmp++;
    if (fq_val.size() != 1 || fq_val[0] !== 16'h8005 || fq_cyc[0] != rd_cyc[3]) begin
      n_bad++; $display("FAIL single_fq: got n=%0d val=%h cyc=%0d want n=1 val=8005 cyc=%0d",
                        fq_val.size(), fq_val[0], fq_cyc[0], rd_cyc[3]);
    end
    n_cmp++;
    if (o_data.size() != 4) begin
      n_bad++; $display("FAIL single_nout: got %0d want 4", o_data.size());
    end
    for (int i = 0; i < 4 && i < o_data.size(); i++) begin
      n_cmp++;
      if (o_port[i] != 1 || o_sop[i] != int'(i == 0) || o_eop[i] != int'(i == 3) ||
          o_data[i] !== mem_word(20 + i)) begin
        n_bad++; $display("FAIL single_out%0d: got port=%0d sop=%0d eop=%0d data=%h want port=1 sop=%0d eop=%0d data=%h",
                          i, o_port[i], o_sop[i], o_eop[i], o_data[i], int'(i == 0), int'(i == 3), mem_word(20 + i));
      end
    end
  endtask

  task automatic test_multi_cell;
    int exp_addr [12] = '{12, 13, 14, 15, 28, 29, 30, 31, 4, 5, 6, 7};
    int exp_ack [3]   = '{2, 2, 0};
    logic [15:0] exp_fq [3] = '{16'h0003, 16'h8007, 16'h8001};
    int ep;
    clear_logs();
    out_ready = 1'b1;
    push_ptr(2, 16'h0003);
    push_ptr(2, 16'h8007);
    push_ptr(0, 16'h8001);
    tick(60);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ack_port.size() != 3 || ack_port[i] != exp_ack[i] || fq_val.size() != 3 || fq_val[i] !== exp_fq[i]) begin
        n_bad++; $display("FAIL multi_ack_fq%0d: got ack=%0d fq=%h want ack=%0d fq=%h",
                          i, ack_port[i], fq_val[i], exp_ack[i], exp_fq[i]);
      end
    end
    n_cmp++;
    if (fq_cyc.size() < 2 || fq_cyc[1] - fq_cyc[0] < 4) begin
      n_bad++; $display("FAIL multi_fq_gap: got %0d want >=4", fq_cyc[1] - fq_cyc[0]);
    end
    n_cmp++;
    if (o_data.size() != 12) begin
      n_bad++; $display("FAIL multi_nout: got %0d want 12", o_data.size());
    end
    for (int i = 0; i < 12 && i < o_data.size(); i++) begin
      ep = (i < 8) ? 2 : 0;
      n_cmp++;
      if (o_port[i] != ep || o_sop[i] != int'(i == 0 || i == 8) || o_eop[i] != int'(i == 7 || i == 11) ||
          o_data[i] !== mem_word(exp_addr[i])) begin
        n_bad++; $display("FAIL multi_out%0d: got port=%0d sop=%0d eop=%0d data=%h want port=%0d sop=%0d eop=%0d data=%h",
                          i, o_port[i], o_sop[i], o_eop[i], o_data[i], ep, int'(i == 0 || i == 8),
                          int'(i == 7 || i == 11), mem_word(exp_addr[i]));
      end
    end
  endtask

  task automatic test_round_robin;
    // Last grant was port 0, so the search starts at port 1 and finds 3 first.
    int exp_ack [6] = '{3, 0, 3, 0, 3, 0};
    logic [15:0] exp_fq [6] = '{16'h8020, 16'h8010, 16'h8021, 16'h8011, 16'h8022, 16'h8012};
    clear_logs();
    out_ready = 1'b1;
    push_ptr(0, 16'h8010); push_ptr(0, 16'h8011); push_ptr(0, 16'h8012);
    push_ptr(3, 16'h8020); push_ptr(3, 16'h8021); push_ptr(3, 16'h8022);
    tick(80);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (ack_port.size() != 6 || ack_port[i] != exp_ack[i] || fq_val[i] !== exp_fq[i]) begin
        n_bad++; $display("FAIL rr_grant%0d: got ack=%0d fq=%h want ack=%0d fq=%h",
                          i, ack_port[i], fq_val[i], exp_ack[i], exp_fq[i]);
      end
    end
    for (int i = 1; i < 6 && i < ack_cyc.size(); i++) begin
      n_cmp++;
      if (ack_cyc[i] - ack_cyc[i-1] < 4) begin
        n_bad++; $display("FAIL rr_gap%0d: got %0d want >=4", i, ack_cyc[i] - ack_cyc[i-1]);
      end
    end
    n_cmp++;
    if (o_data.size() != 24) begin
      n_bad++; $display("FAIL rr_nout: got %0d want 24", o_data.size());
    end
    for (int i = 0; i < 24 && i < o_data.size(); i += 4) begin
      n_cmp++;
      if (o_port[i] != exp_ack[i/4] || o_sop[i] != 1 || o_data[i] !== mem_word(int'(exp_fq[i/4][8:0]) * 4)) begin
        n_bad++; $display("FAIL rr_out%0d: got port=%0d sop=%0d data=%h want port=%0d sop=1 data=%h",
                          i, o_port[i], o_sop[i], o_data[i], exp_ack[i/4], mem_word(int'(exp_fq[i/4][8:0]) * 4));
      end
    end
  endtask

  task automatic test_backpressure;
    int resume_cyc;
    int j;
    clear_logs();
    out_ready = 1'b1;
    push_ptr(1, 16'h0009);
    push_ptr(1, 16'h800A);
    for (int k = 0; k < 40 && o_data.size() == 0; k++) tick(1);
    n_cmp++;
    if (o_data.size() == 0) begin
      n_bad++; $display("FAIL bp_start: got no output word want one within 40 cycles");
    end
    out_ready = 1'b0;
    tick(10);
    out_ready = 1'b1;
    resume_cyc = cyc + 1;
    tick(30);
    n_cmp++;
    if (o_data.size() != 8) begin
      n_bad++; $display("FAIL bp_nout: got %0d want 8", o_data.size());
    end
    for (int i = 0; i < 8 && i < o_data.size(); i++) begin
      n_cmp++;
      if (o_port[i] != 1 || o_sop[i] != int'(i == 0) || o_eop[i] != int'(i == 7) ||
          o_data[i] !== mem_word(36 + i)) begin
        n_bad++; $display("FAIL bp_out%0d: got port=%0d sop=%0d eop=%0d data=%h want port=1 sop=%0d eop=%0d data=%h",
                          i, o_port[i], o_sop[i], o_eop[i], o_data[i], int'(i == 0), int'(i == 7), mem_word(36 + i));
      end
    end
    n_cmp++;
    if (max_occ != 4) begin
      n_bad++; $display("FAIL bp_occupancy: got %0d want 4", max_occ);
    end
    j = 0;
    while (j < o_cyc.size() && o_cyc[j] < resume_cyc) j++;
    n_cmp++;
    if (j != 1) begin
      n_bad++; $display("FAIL bp_stall: got %0d words before resume want 1", j);
    end
    for (int k = 0; k < 4 && j + k < o_cyc.size(); k++) begin
      n_cmp++;
      if (o_cyc[j+k] != resume_cyc + k) begin
        n_bad++; $display("FAIL bp_resume%0d: got cyc=%0d want %0d", k, o_cyc[j+k], resume_cyc + k);
      end
    end
  endtask

  task automatic test_reset_mid_cell;
    clear_logs();
    out_ready = 1'b1;
    push_ptr(2, 16'h8004);
    for (int k = 0; k < 40 && rd_addr.size() < 2; k++) tick(1);
    n_cmp++;
    if (rd_addr.size() < 2) begin
      n_bad++; $display("FAIL rstmid_start: got %0d reads want 2", rd_addr.size());
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if ({ptr_ack, cell_rd_en, cell_rd_addr, FQ_wr, FQ_din, out_valid, out_port, out_data, out_sop, out_eop} !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs: got ack=%h rd=%b fq=%b v=%b data=%h want all 0",
                        ptr_ack, cell_rd_en, FQ_wr, out_valid, out_data);
    end
    n_cmp++;
    if (fq_val.size() != 0) begin
      n_bad++; $display("FAIL rstmid_fq: got %0d returns want 0", fq_val.size());
    end
    tick(1);
    clear_logs();
    push_ptr(0, 16'h8011);
    push_ptr(3, 16'h8012);
    tick(40);
    n_cmp++;
    if (ack_port.size() != 2 || ack_port[0] != 0 || ack_port[1] != 3) begin
      n_bad++; $display("FAIL rstmid_rr: got n=%0d first=%0d second=%0d want n=2 first=0 second=3",
                        ack_port.size(), ack_port[0], ack_port[1]);
    end
    n_cmp++;
    if (o_data.size() != 8 || o_port[0] != 0 || o_sop[0] != 1 || o_data[0] !== mem_word(68)) begin
      n_bad++; $display("FAIL rstmid_out: got n=%0d port=%0d sop=%0d data=%h want n=8 port=0 sop=1 data=%h",
                        o_data.size(), o_port[0], o_sop[0], o_data[0], mem_word(68));
    end
    n_cmp++;
    if (fq_val.size() != 2 || fq_val[0] !== 16'h8011 || fq_val[1] !== 16'h8012) begin
      n_bad++; $display("FAIL rstmid_fqret: got n=%0d %h %h want n=2 8011 8012",
                        fq_val.size(), fq_val[0], fq_val[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single_cell();
    test_multi_cell();
    test_round_robin();
    test_backpressure();
    test_reset_mid_cell();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
